// File: rtl/sfx_pkg.sv
// sfx_pkg: effect ids, script table and state encoding shared by the sound-effect sequencer
package sfx_pkg;
  localparam logic [1:0] FX_DIE = 2'd0, FX_KILL = 2'd1, FX_UFO = 2'd2, FX_SHOT = 2'd3;
  typedef enum logic [1:0] {SW_NONE, SW_UP, SW_DOWN, SW_ALT8} sweep_e;
  typedef enum logic {G_ON, G_CHOP2} gate_e;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;
  function automatic logic [7:0] fx_len(input logic [1:0] id);
    return id == FX_DIE ? 8'd60 : id == FX_KILL ? 8'd15 : id == FX_UFO ? 8'd40 : 8'd10;
  endfunction
  function automatic sweep_e fx_sweep(input logic [1:0] id);
    return id == FX_SHOT ? SW_UP : id == FX_UFO ? SW_ALT8 : SW_DOWN;
  endfunction
  function automatic gate_e fx_gate(input logic [1:0] id);
    return id == FX_DIE ? G_CHOP2 : G_ON;
  endfunction
  // {f_up, f_dn, gate}; only frame bits 1 (chop) and 3 (alternate sweep) matter
  function automatic logic [2:0] fx_ctl(input logic [1:0] id, input logic f1, input logic f3);
    sweep_e sw;
    sw = fx_sweep(id);
    return {sw == SW_UP || (sw == SW_ALT8 && !f3),
            sw == SW_DOWN || (sw == SW_ALT8 && f3),
            fx_gate(id) == G_ON || !f1};
  endfunction
endpackage

// File: rtl/sfx_prio_enc.sv
// sfx_prio_enc: fixed-priority pick of pending effects, lowest index wins
module sfx_prio_enc (
  input  logic [3:0] pend,
  input  logic [1:0] cur,
  output logic       valid,
  output logic [1:0] id,
  output logic       higher
);
  assign valid = |pend;
  assign id = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
  assign higher = |(pend & ((4'd1 << cur) - 4'd1));
endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: latches effect requests and scripts the tone generator controls frame by frame
module sfx_sequencer import sfx_pkg::*; #(
  parameter int FRAME_DIV = 417,
  parameter int FRM_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [3:0] req,
  output logic       freq_rst,
  output logic       f_up,
  output logic       f_dn,
  output logic       gate,
  output logic       busy,
  output logic [1:0] cur_id,
  output logic       done
);
  state_e state;
  logic [3:0] pending, clr;
  logic [15:0] sample_cnt;
  logic [FRM_W-1:0] frame_cnt, frame_nxt;
  logic valid, higher, wrap, last;
  logic [1:0] top_id;
  logic [2:0] ctl;
  sfx_prio_enc u_enc (.pend(pending), .cur(cur_id), .valid(valid), .id(top_id), .higher(higher));
  assign wrap = ena && sample_cnt == 16'(FRAME_DIV - 1);
  assign last = wrap && frame_cnt == FRM_W'(fx_len(cur_id) - 8'd1);
  assign frame_nxt = wrap ? frame_cnt + FRM_W'(1) : frame_cnt;
  assign clr = state == LOAD ? 4'b0001 << top_id : 4'b0000;
  // outputs are registered, so look up the script for the frame being entered
  assign ctl = state == LOAD ? fx_ctl(top_id, 1'b0, 1'b0) : fx_ctl(cur_id, frame_nxt[1], frame_nxt[3]);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      sample_cnt <= '0;
      frame_cnt <= '0;
      cur_id <= '0;
      {freq_rst, f_up, f_dn, gate, busy, done} <= '0;
    end else begin
      pending <= (pending & ~clr) | req;
      freq_rst <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          state <= LOAD;
          freq_rst <= 1'b1;
          busy <= 1'b1;
        end
        LOAD: begin
          cur_id <= top_id;
          sample_cnt <= '0;
          frame_cnt <= '0;
          {f_up, f_dn, gate} <= ctl;
          state <= PLAY;
        end
        PLAY: begin
          sample_cnt <= wrap ? 16'd0 : sample_cnt + 16'(ena);
          frame_cnt <= frame_nxt;
          {f_up, f_dn, gate} <= ctl;
          // completion takes precedence over preemption in the same cycle
          if (last || higher) begin
            {f_up, f_dn, gate} <= 3'b000;
            done <= last;
            state <= valid ? LOAD : IDLE;
            freq_rst <= valid;
            busy <= valid;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed scenarios with a scoreboard of expected completions
module tb_sfx_sequencer;
  logic clk, reset, ena;
  logic [3:0] req;
  logic freq_rst, f_up, f_dn, gate, busy, done;
  logic [1:0] cur_id;
  int checks = 0, errors = 0;
  int sb[$];
  int ncyc;

  sfx_sequencer #(.FRAME_DIV(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .req(req), .freq_rst(freq_rst),
    .f_up(f_up), .f_dn(f_dn), .gate(gate), .busy(busy), .cur_id(cur_id), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // ena high at every other posedge; changes just after a negedge
  initial begin
    ena = 0;
    #11;
    forever begin
      ena = 1;
      #10;
      ena = 0;
      #10;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_ctl(input int id, input int f);
    case (id)
      0: return {1'b0, 1'b1, (f % 4) < 2};
      1: return 3'b011;
      2: return {(f % 16) < 8, (f % 16) >= 8, 1'b1};
      default: return 3'b101;
    endcase
  endfunction

  function automatic int exp_len(input int id);
    case (id)
      0: return 60;
      1: return 15;
      2: return 40;
      default: return 10;
    endcase
  endfunction

  task automatic wait_load(input string tag);
    int n = 0;
    while (freq_rst !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 8'(freq_rst), 8'd1);
    chk({tag, "_quiet"}, 8'({busy, f_up, f_dn, gate}), 8'b1000);
  endtask

  // entered on the LOAD cycle; follows the script until done or the given frame
  task automatic play(input int id, input int stop_f, input logic [3:0] rereq, input logic nxt);
    int s = 0, f = 0, len;
    len = exp_len(id);
    ncyc = 0;
    req = rereq;
    @(negedge clk);
    req = '0;
    chk("cur_id", 8'(cur_id), 8'(id));
    chk("frame0", 8'({freq_rst, done, f_up, f_dn, gate}), 8'({2'b00, exp_ctl(id, 0)}));
    ncyc++;
    while (f < len) begin
      @(negedge clk);
      if (ena) begin
        s++;
        if (s == 4) begin
          s = 0;
          f++;
        end
      end
      if (f == len) begin
        chk("done", 8'({freq_rst, done, f_up, f_dn, gate}), 8'({nxt, 1'b1, 3'b000}));
        chk("busy_end", 8'(busy), 8'(nxt));
        if (sb.size() == 0) chk("sb_empty_at_done", 8'd1, 8'(sb.size()));
        else chk("sb_id", 8'(cur_id), 8'(sb.pop_front()));
      end else begin
        chk("script", 8'({freq_rst, done, f_up, f_dn, gate}), 8'({2'b00, exp_ctl(id, f)}));
        ncyc++;
        if (f == stop_f) break;
      end
    end
  endtask

  initial begin
    int act;
    reset = 1;
    req = '0;
    repeat (3) @(negedge clk);
    chk("reset", 8'({freq_rst, f_up, f_dn, gate, busy, cur_id, done}), 8'd0);
    reset = 0;
    @(negedge clk);
    if ((($time / 10) % 2) == 0) @(negedge clk);
    // shot from idle, ena phase fixed so the effect spans exactly 80 clocks
    req = 4'b1000;
    sb.push_back(3);
    @(negedge clk);
    req = '0;
    chk("lat1", 8'({freq_rst, busy}), 8'b00);
    @(negedge clk);
    chk("lat2", 8'({freq_rst, busy, gate}), 8'b110);
    play(3, 99, 4'b0000, 1'b0);
    chk("shot_cycles", 8'(ncyc), 8'd80);
    @(negedge clk);
    chk("idle_after", 8'({freq_rst, f_up, f_dn, gate, busy, done}), 8'd0);
    // two requests together, kill before shot, back to back
    req = 4'b1010;
    sb.push_back(1);
    sb.push_back(3);
    @(negedge clk);
    req = '0;
    wait_load("load_kill");
    play(1, 99, 4'b0000, 1'b1);
    play(3, 99, 4'b0000, 1'b0);
    // ufo alone
    req = 4'b0100;
    sb.push_back(2);
    @(negedge clk);
    req = '0;
    wait_load("load_ufo");
    play(2, 99, 4'b0000, 1'b0);
    // ufo preempted by player_die at frame 5
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    wait_load("load_ufo2");
    play(2, 5, 4'b0000, 1'b0);
    req = 4'b0001;
    sb.push_back(0);
    @(negedge clk);
    req = '0;
    chk("pre1", 8'({freq_rst, done}), 8'b00);
    @(negedge clk);
    chk("pre2", 8'({freq_rst, done, busy, gate}), 8'b1010);
    play(0, 99, 4'b0000, 1'b0);
    // reset during player_die with shot pending
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_load("load_die");
    play(0, 3, 4'b0000, 1'b0);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    reset = 1;
    @(negedge clk);
    chk("mid_reset", 8'({freq_rst, f_up, f_dn, gate, busy, cur_id, done}), 8'd0);
    reset = 0;
    act = 0;
    repeat (30) begin
      @(negedge clk);
      act += int'(busy | freq_rst | gate | done);
    end
    chk("quiet", 8'(act), 8'd0);
    // shot re-requested during its own LOAD cycle replays
    req = 4'b1000;
    sb.push_back(3);
    sb.push_back(3);
    @(negedge clk);
    req = '0;
    wait_load("load_re");
    play(3, 99, 4'b1000, 1'b1);
    play(3, 99, 4'b0000, 1'b0);
    @(negedge clk);
    chk("final_idle", 8'({busy, freq_rst}), 8'd0);
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
